sangdich_checker: RTL and testbench
===================================

Name: sangdich_checker

Overview:
- Receive-side monitor for the 8-bit running-light (LED chaser) bus.
- Samples `led` every `clk` and locks onto a single-hot rotating pattern.
- Checks every transition against the expected next position and counts steps and full revolutions.
- Flags stalls and illegal steps. Sits beside the chaser on the board, or in benches, as a self-checking sink for the `led` bus.

Parameters:
- DIR, 0, rotation direction: 0 = left (bit0→bit7, bit7 wraps to bit0), 1 = right.
- STALL_MAX, 50_000_000, cycles a value may hold before a stall fault is raised. Must be ≥ 2.
- HW, 26, width of the hold counter. Must satisfy 2^HW > STALL_MAX.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rs  in  1  reset, synchronous, active-high.
- led  in  8  observed LED bus.
- clr  in  1  synchronous pulse: leave FAULT and re-hunt. Ignored outside FAULT.
- locked  out  1  high while in TRACK.
- fault  out  1  high while in FAULT (sticky).
- fault_code  out  2  00 none, 01 BADSTEP, 10 STALL, 11 LOSTHOT.
- step_cnt  out  16  legal steps since lock; saturates at 16'hFFFF.
- rev_cnt  out  8  completed revolutions since lock; wraps modulo 256.

Behaviour:
- Reset (`rs`=1 at an edge) forces:
  - state=HUNT; led_q=0, hold_cnt=0, start_pos=0, expected=0.
  - locked=0, fault=0, fault_code=00, step_cnt=0, rev_cnt=0.
  - `rs` wins over every other condition, including mid-TRACK and mid-FAULT.
- Helper terms:
  - led_q is `led` registered every cycle.
  - chg = (led != led_q).
  - onehot(x) = exactly one bit of x set.
  - rot(x) = {x[6:0],x[7]} when DIR=0, {x[0],x[7:1]} when DIR=1.
- All outputs are registered. A `led` value sampled at edge N is reflected in the outputs after edge N; there are no combinational paths to outputs.
- HUNT:
  - If onehot(led): go to TRACK; expected=rot(led); start_pos=led; hold_cnt=0; step_cnt=0; rev_cnt=0; locked=1.
  - Otherwise stay in HUNT. Zero and multi-hot values are ignored.
- TRACK, evaluated in this priority order:
  1. If chg and led==expected: step_cnt += 1 (saturating); expected=rot(led); hold_cnt=0. If led==start_pos, rev_cnt += 1.
  2. If chg and !onehot(led): FAULT, code 11.
  3. If chg and onehot(led) but led != expected: FAULT, code 01. A skipped position or a reversed direction both count.
  4. If !chg: hold_cnt += 1. When hold_cnt reaches STALL_MAX−1 on this edge (held STALL_MAX cycles), go to FAULT, code 10.
- FAULT:
  - locked=0, fault=1; fault_code, step_cnt and rev_cnt are frozen.
  - `clr`=1 → HUNT, fault=0, code=00, hold_cnt=0; counters keep their values until the next lock.
  - `led` activity is ignored.
- Simultaneous events:
  - `rs` and `clr` together: reset wins.
  - A legal step on the same edge hold_cnt would expire: the step wins and hold_cnt clears.
- Saturation and wrap:
  - step_cnt holds at FFFF without a fault.
  - rev_cnt wraps FF→00 silently.
- State encoding: 2 bits, HUNT=0, TRACK=1, FAULT=2. The unused code 3 recovers to HUNT on the next edge.

Decomposition:
- Shared package `sangdich_pkg`:
  - state encoding constants.
  - fault_code constants NONE/BADSTEP/STALL/LOSTHOT.
  - the `rot` function, shared with the chaser so both ends agree on direction.
- One natural sub-module, `onehot_detect`: combinational, 8-bit in, 1-bit out.
- The counters stay inline.

Test Plan:
1. Reset, then `led` = 01,02,04,…,80,01, each held 3 cycles, DIR=0, STALL_MAX=8 → locked=1 after the first 01; after the final 01, step_cnt=8, rev_cnt=1, fault=0.
2. Locked at 04, then `led`=10 (skips 08) → fault=1, fault_code=01, locked=0, step_cnt frozen at its value before the skip.
3. Locked, `led` held at 20 for 8 cycles with STALL_MAX=8 → fault_code=10 after the 8th cycle. Holding for only 7 cycles, then stepping to 40, gives no fault.
4. Locked at 02, `led`=06 → fault_code=11. Then `clr`=1 for one cycle → state HUNT, fault=0. Then `led`=08 → locked=1, step_cnt=0.
5. HUNT with `led`=00, then FF, then 03 for 10 cycles each → locked remains 0 and fault remains 0.
6. Mid-TRACK with step_cnt=5, assert `rs` for one edge → every output returns to its reset value on that edge. With DIR=1, the sequence 80,40,20 then advances step_cnt to 2.

Source files
------------

// File: rtl/sangdich_pkg.sv
// Shared definitions for the LED chaser and its receive-side checker.
// The rot() helper is the single source of truth for rotation direction.
package sangdich_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_BADSTEP = 2'b01;
    localparam logic [1:0] FC_STALL   = 2'b10;
    localparam logic [1:0] FC_LOSTHOT = 2'b11;

    // dir = 0 moves the lit bit toward the MSB, dir = 1 toward the LSB.
    function automatic logic [7:0] rot(input logic [7:0] x, input logic dir);
        return dir ? {x[0], x[7:1]} : {x[6:0], x[7]};
    endfunction

endpackage

// File: rtl/sangdich_checker_onehot.sv
// Combinational single-hot detector for the 8-bit LED bus.
module onehot_detect (
    input  logic [7:0] data_i,
    output logic       onehot_o
);

    logic [7:0] dataMinusOne;

    // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
    assign dataMinusOne = data_i - 8'd1;
    assign onehot_o     = (data_i != 8'd0) && ((data_i & dataMinusOne) == 8'd0);

endmodule

// File: rtl/sangdich_checker.sv
// Receive-side monitor for the running-light bus: locks onto a single-hot
// rotating pattern, checks each step, counts steps/revolutions, flags faults.
module sangdich_checker
    import sangdich_pkg::*;
#(
    parameter bit DIR       = 1'b0,
    parameter int STALL_MAX = 50_000_000,
    parameter int HW        = 26
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [7:0] led,
    input  logic       clr,
    output logic       locked,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [15:0] step_cnt,
    output logic [7:0]  rev_cnt
);

    // The stall trips on the edge where hold_cnt would become STALL_MAX-1.
    localparam logic [HW-1:0] HOLD_TRIP = HW'(STALL_MAX - 2);

    state_e      state_q, state_d;
    logic [7:0]  led_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]  start_q, start_d;
    logic [7:0]  expected_q, expected_d;
    logic [1:0]  code_q, code_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  rev_q, rev_d;

    logic ledHot;
    logic chg;

    onehot_detect u_onehot (
        .data_i   (led),
        .onehot_o (ledHot)
    );

    assign chg = (led != led_q);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        start_d    = start_q;
        expected_d = expected_q;
        code_d     = code_q;
        step_d     = step_q;
        rev_d      = rev_q;

        case (state_q)
            HUNT: begin
                if (ledHot) begin
                    state_d    = TRACK;
                    expected_d = rot(led, DIR);
                    start_d    = led;
                    hold_d     = '0;
                    step_d     = '0;
                    rev_d      = '0;
                end
            end
            TRACK: begin
                if (chg && (led == expected_q)) begin
                    if (step_q != 16'hFFFF) begin
                        step_d = step_q + 16'd1;
                    end
                    if (led == start_q) begin
                        rev_d = rev_q + 8'd1;
                    end
                    expected_d = rot(led, DIR);
                    hold_d     = '0;
                end else if (chg && !ledHot) begin
                    state_d = FAULT;
                    code_d  = FC_LOSTHOT;
                end else if (chg) begin
                    state_d = FAULT;
                    code_d  = FC_BADSTEP;
                end else begin
                    hold_d = hold_q + HW'(1);
                    if (hold_q == HOLD_TRIP) begin
                        state_d = FAULT;
                        code_d  = FC_STALL;
                    end
                end
            end
            FAULT: begin
                if (clr) begin
                    state_d = HUNT;
                    code_d  = FC_NONE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q    <= HUNT;
            led_q      <= '0;
            hold_q     <= '0;
            start_q    <= '0;
            expected_q <= '0;
            code_q     <= FC_NONE;
            step_q     <= '0;
            rev_q      <= '0;
        end else begin
            state_q    <= state_d;
            led_q      <= led;
            hold_q     <= hold_d;
            start_q    <= start_d;
            expected_q <= expected_d;
            code_q     <= code_d;
            step_q     <= step_d;
            rev_q      <= rev_d;
        end
    end

    assign locked     = (state_q == TRACK);
    assign fault      = (state_q == FAULT);
    assign fault_code = code_q;
    assign step_cnt   = step_q;
    assign rev_cnt    = rev_q;

endmodule

// File: tb/tb_sangdich_checker.sv
// Directed bench for sangdich_checker: a DIR=0 and a DIR=1 instance share
// the same LED bus, with STALL_MAX=8 so stall boundaries are short.
module tb_sangdich_checker;

    logic        clk = 1'b0;
    logic        rs  = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  led = 8'h00;

    logic        locked0, fault0, locked1, fault1;
    logic [1:0]  code0, code1;
    logic [15:0] step0, step1;
    logic [7:0]  rev0, rev1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sangdich_checker #(.DIR(1'b0), .STALL_MAX(8), .HW(4)) dut0 (
        .clk        (clk),
        .rs         (rs),
        .led        (led),
        .clr        (clr),
        .locked     (locked0),
        .fault      (fault0),
        .fault_code (code0),
        .step_cnt   (step0),
        .rev_cnt    (rev0)
    );

    sangdich_checker #(.DIR(1'b1), .STALL_MAX(8), .HW(4)) dut1 (
        .clk        (clk),
        .rs         (rs),
        .led        (led),
        .clr        (clr),
        .locked     (locked1),
        .fault      (fault1),
        .fault_code (code1),
        .step_cnt   (step1),
        .rev_cnt    (rev1)
    );

    // Drive inputs on the falling edge for n rising edges, then settle 1 time unit.
    task automatic applyStimulus(input logic [7:0] v, input logic c, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            led = v;
            clr = c;
            rs  = r;
            @(posedge clk);
        end
        #1;
        clr = 1'b0;
        rs  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_locked"}, 32'(locked0), 32'd0);
        checkOutput({tag, "_fault"},  32'(fault0),  32'd0);
        checkOutput({tag, "_code"},   32'(code0),   32'd0);
        checkOutput({tag, "_step"},   32'(step0),   32'd0);
        checkOutput({tag, "_rev"},    32'(rev0),    32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] seq [9];
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        $display("[TB] reset");
        applyStimulus(8'h00, 1'b0, 1'b1, 2);
        checkReset("reset");

        $display("[TB] full revolution");
        applyStimulus(seq[0], 1'b0, 1'b0, 1);
        checkOutput("lock_first", 32'(locked0), 32'd1);
        applyStimulus(seq[0], 1'b0, 1'b0, 2);
        for (int i = 1; i < 9; i++) begin
            applyStimulus(seq[i], 1'b0, 1'b0, 3);
        end
        checkOutput("rev_step",   32'(step0),   32'd8);
        checkOutput("rev_rev",    32'(rev0),    32'd1);
        checkOutput("rev_fault",  32'(fault0),  32'd0);
        checkOutput("rev_locked", 32'(locked0), 32'd1);

        $display("[TB] skipped position");
        applyStimulus(8'h02, 1'b0, 1'b0, 3);
        applyStimulus(8'h04, 1'b0, 1'b0, 3);
        checkOutput("pre_skip_step", 32'(step0), 32'd10);
        applyStimulus(8'h10, 1'b0, 1'b0, 1);
        checkOutput("skip_fault",  32'(fault0),  32'd1);
        checkOutput("skip_code",   32'(code0),   32'd1);
        checkOutput("skip_locked", 32'(locked0), 32'd0);
        checkOutput("skip_step",   32'(step0),   32'd10);
        applyStimulus(8'h20, 1'b0, 1'b0, 2);
        checkOutput("fault_sticky", 32'(code0), 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1);
        checkOutput("clr_fault", 32'(fault0), 32'd0);
        checkOutput("clr_code",  32'(code0),  32'd0);
        checkOutput("clr_step",  32'(step0),  32'd10);
        checkOutput("clr_rev",   32'(rev0),   32'd1);

        $display("[TB] stall boundary");
        applyStimulus(8'h20, 1'b0, 1'b0, 1);
        checkOutput("stall_lock", 32'(locked0), 32'd1);
        checkOutput("stall_step0", 32'(step0), 32'd0);
        applyStimulus(8'h20, 1'b0, 1'b0, 6);
        checkOutput("hold7_fault", 32'(fault0), 32'd0);
        applyStimulus(8'h40, 1'b0, 1'b0, 1);
        checkOutput("hold7_step", 32'(step0), 32'd1);
        applyStimulus(8'h40, 1'b0, 1'b0, 6);
        checkOutput("hold7b_fault", 32'(fault0), 32'd0);
        applyStimulus(8'h40, 1'b0, 1'b0, 1);
        checkOutput("stall_fault", 32'(fault0), 32'd1);
        checkOutput("stall_code",  32'(code0),  32'd2);
        checkOutput("stall_step",  32'(step0),  32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1);

        $display("[TB] lost single-hot");
        applyStimulus(8'h02, 1'b0, 1'b0, 1);
        applyStimulus(8'h06, 1'b0, 1'b0, 1);
        checkOutput("lost_code", 32'(code0), 32'd3);
        applyStimulus(8'h06, 1'b1, 1'b0, 1);
        checkOutput("lost_clr_fault", 32'(fault0), 32'd0);
        applyStimulus(8'h06, 1'b0, 1'b0, 1);
        checkOutput("lost_hunt", 32'(locked0), 32'd0);
        applyStimulus(8'h08, 1'b0, 1'b0, 1);
        checkOutput("relock",      32'(locked0), 32'd1);
        checkOutput("relock_step", 32'(step0),   32'd0);
        checkOutput("relock_rev",  32'(rev0),    32'd0);

        $display("[TB] hunt ignores non single-hot");
        applyStimulus(8'h00, 1'b0, 1'b0, 1);
        checkOutput("zero_lost", 32'(code0), 32'd3);
        applyStimulus(8'h00, 1'b1, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 1'b0, 10);
        checkOutput("hunt00_locked", 32'(locked0), 32'd0);
        checkOutput("hunt00_fault",  32'(fault0),  32'd0);
        applyStimulus(8'hFF, 1'b0, 1'b0, 10);
        checkOutput("huntFF_locked", 32'(locked0), 32'd0);
        checkOutput("huntFF_fault",  32'(fault0),  32'd0);
        applyStimulus(8'h03, 1'b0, 1'b0, 10);
        checkOutput("hunt03_locked", 32'(locked0), 32'd0);
        checkOutput("hunt03_fault",  32'(fault0),  32'd0);

        $display("[TB] reset mid-track and right rotation");
        applyStimulus(8'h01, 1'b0, 1'b0, 1);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(seq[i], 1'b0, 1'b0, 1);
        end
        checkOutput("mid_step", 32'(step0), 32'd5);
        applyStimulus(8'h40, 1'b0, 1'b1, 1);
        checkReset("midreset");
        applyStimulus(8'h80, 1'b0, 1'b0, 1);
        applyStimulus(8'h40, 1'b0, 1'b0, 1);
        applyStimulus(8'h20, 1'b0, 1'b0, 1);
        checkOutput("right_step",   32'(step1),   32'd2);
        checkOutput("right_locked", 32'(locked1), 32'd1);
        checkOutput("right_fault",  32'(fault1),  32'd0);
        checkOutput("reverse_code", 32'(code0),   32'd1);

        applyStimulus(8'h00, 1'b1, 1'b1, 1);
        checkReset("rsclr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
